// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR tap sequencer slice.
// Holds the sequencer state encoding, the default Q15/Q30 widths and a
// helper that sizes the tap-index buses from the filter length.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACC,
        ST_DRAIN,
        ST_OUT
    } fir_state_t;

    localparam int DEF_NUM_TAPS    = 32;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COEFF_WIDTH = 16;
    localparam int DEF_ACCUM_WIDTH = 35;
    localparam int DEF_FRAC_SHIFT  = 15;

    // Width of a tap index; never narrower than one bit.
    function automatic int tapIdxWidth(input int numTaps);
        return (numTaps < 2) ? 1 : $clog2(numTaps);
    endfunction

endpackage

// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer: turns the Q30 MAC accumulator into a Q15 sample.
// Rounds half-up, arithmetic-shifts by FRAC_SHIFT at ACCUM_WIDTH+1 bits,
// then either clips (FIR_SAT_EN defined) or wraps (FIR_SAT_EN undefined).
module fir_output_quantizer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT
) (
    input  logic signed [ACCUM_WIDTH-1:0] i_acc,
    output logic signed [DATA_WIDTH-1:0]  o_data,
    output logic                          o_sat
);

    localparam logic [ACCUM_WIDTH:0] ROUND_HALF = (ACCUM_WIDTH + 1)'(1) << (FRAC_SHIFT - 1);

    logic signed [ACCUM_WIDTH:0] w_sum;
    logic signed [ACCUM_WIDTH:0] w_shifted;

    assign w_sum     = $signed({i_acc[ACCUM_WIDTH-1], i_acc}) + $signed(ROUND_HALF);
    assign w_shifted = w_sum >>> FRAC_SHIFT;

`ifdef FIR_SAT_EN
    logic [ACCUM_WIDTH-DATA_WIDTH+1:0] w_upper;

    assign w_upper = w_shifted[ACCUM_WIDTH:DATA_WIDTH-1];

    // Result fits when all bits from the Q15 sign upward agree; otherwise clip toward the sign.
    always_comb begin
        o_data = w_shifted[DATA_WIDTH-1:0];
        o_sat  = 1'b0;
        if (!((&w_upper) || !(|w_upper))) begin
            o_sat = 1'b1;
            if (w_shifted[ACCUM_WIDTH]) begin
                o_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                o_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end
`else
    logic w_unused;

    assign w_unused = ^w_shifted[ACCUM_WIDTH:DATA_WIDTH];

    // Without clipping the low Q15 bits are passed through and wrap on overflow.
    always_comb begin
        o_data = w_shifted[DATA_WIDTH-1:0];
        o_sat  = 1'b0;
    end
`endif

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: accepts one Q15 sample, stores it in a circular delay
// line, streams NUM_TAPS (sample, coefficient) pairs into an external MAC,
// then presents the quantised result with a valid/ready handshake.
// Output clipping is selected by the FIR_SAT_EN macro (see the quantizer).
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int NUM_TAPS    = DEF_NUM_TAPS,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter  int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    parameter  int FRAC_SHIFT  = DEF_FRAC_SHIFT,
    localparam int TAP_IDX_W   = tapIdxWidth(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          coef_wr_en,
    input  logic [TAP_IDX_W-1:0]          coef_wr_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_wr_data,
    output logic signed [DATA_WIDTH-1:0]  mac_sample,
    output logic signed [COEFF_WIDTH-1:0] mac_coeff,
    output logic                          mac_en,
    output logic                          mac_clr,
    input  logic signed [ACCUM_WIDTH-1:0] mac_acc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          out_sat,
    output logic                          busy
);

    localparam logic [TAP_IDX_W:0]   TAP_COUNT = (TAP_IDX_W + 1)'(NUM_TAPS);
    localparam logic [TAP_IDX_W-1:0] TAP_MOD   = TAP_IDX_W'(NUM_TAPS);
    localparam logic [TAP_IDX_W-1:0] TAP_LAST  = TAP_IDX_W'(NUM_TAPS - 1);
    localparam logic [TAP_IDX_W-1:0] TAP_ONE   = TAP_IDX_W'(1);

    fir_state_t r_state;
    fir_state_t w_nextState;

    logic signed [DATA_WIDTH-1:0]  r_buf  [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];
    logic [TAP_IDX_W-1:0]          r_wrPtr;
    logic [TAP_IDX_W-1:0]          r_base;
    logic [TAP_IDX_W-1:0]          r_tap;
    logic signed [DATA_WIDTH-1:0]  r_outData;
    logic                          r_outSat;

    logic [TAP_IDX_W-1:0]          w_rdIdx;
    logic                          w_accept;
    logic                          w_coefWrite;
    logic                          w_idleReady;
    logic signed [DATA_WIDTH-1:0]  w_qData;
    logic                          w_qSat;

    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    assign w_coefWrite = coef_wr_en && ((r_state == ST_IDLE) || (r_state == ST_OUT))
                         && ({1'b0, coef_wr_addr} < TAP_COUNT);
    assign in_ready    = w_idleReady && !reset;
    assign out_data    = r_outData;
    assign out_sat     = r_outSat;

    fir_output_quantizer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .FRAC_SHIFT  (FRAC_SHIFT)
    ) u_quantizer (
        .i_acc  (mac_acc),
        .o_data (w_qData),
        .o_sat  (w_qSat)
    );

    // Delay-line read index walks backwards from the newest sample, wrapping mod NUM_TAPS.
    always_comb begin
        if (r_base >= r_tap) begin
            w_rdIdx = r_base - r_tap;
        end else begin
            w_rdIdx = r_base + TAP_MOD - r_tap;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and state-decoded MAC/handshake outputs.
    always_comb begin
        w_nextState = r_state;
        w_idleReady = 1'b0;
        busy        = 1'b1;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        mac_sample  = '0;
        mac_coeff   = '0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idleReady = 1'b1;
                busy        = 1'b0;
                if (in_valid) begin
                    w_nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr     = 1'b1;
                w_nextState = ST_ACC;
            end
            ST_ACC: begin
                mac_en     = 1'b1;
                mac_sample = r_buf[w_rdIdx];
                mac_coeff  = r_coef[r_tap];
                if (r_tap == TAP_LAST) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_nextState = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Store the accepted sample, remember where it went and advance the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wrPtr <= '0;
            r_base  <= '0;
        end else if (w_accept) begin
            r_buf[r_wrPtr] <= in_data;
            r_base         <= r_wrPtr;
            r_wrPtr        <= (r_wrPtr == TAP_LAST) ? '0 : r_wrPtr + TAP_ONE;
        end
    end

    // Tap counter steps once per ACC cycle and is back at zero when ACC ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tap <= '0;
        end else if (r_state == ST_ACC) begin
            r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + TAP_ONE;
        end
    end

    // Coefficient file only changes while no sum is in flight, so a result never mixes old and new taps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_coefWrite) begin
            r_coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Capture the quantised sum in DRAIN, when the MAC has absorbed the last tap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outData <= '0;
            r_outSat  <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_outData <= w_qData;
            r_outSat  <= w_qSat;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed test of fir_tap_sequencer with NUM_TAPS=4
// and a behavioural MAC. Expected values depend on FIR_SAT_EN.
module tb_fir_tap_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        coef_wr_en = 1'b0;
    logic [1:0]  coef_wr_addr = '0;
    logic [15:0] coef_wr_data = '0;
    logic [15:0] mac_sample;
    logic [15:0] mac_coeff;
    logic        mac_en;
    logic        mac_clr;
    logic [34:0] mac_acc;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
    logic        busy;
    logic [34:0] macProd;

    int checks = 0;
    int errors = 0;

`ifdef FIR_SAT_EN
    localparam logic [15:0] SAT_EXP  = 16'h7FFF;
    localparam logic        SAT_FLAG = 1'b1;
    localparam logic [15:0] NEG_EXP  = 16'h7FFF;
    localparam logic        NEG_FLAG = 1'b1;
`else
    localparam logic [15:0] SAT_EXP  = 16'hFFF8;
    localparam logic        SAT_FLAG = 1'b0;
    localparam logic [15:0] NEG_EXP  = 16'h8000;
    localparam logic        NEG_FLAG = 1'b0;
`endif

    fir_tap_sequencer #(
        .NUM_TAPS    (4),
        .DATA_WIDTH  (16),
        .COEFF_WIDTH (16),
        .ACCUM_WIDTH (35),
        .FRAC_SHIFT  (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .mac_sample   (mac_sample),
        .mac_coeff    (mac_coeff),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .mac_acc      (mac_acc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    assign macProd = $signed({{19{mac_sample[15]}}, mac_sample}) * $signed({{19{mac_coeff[15]}}, mac_coeff});

    // Behavioural MAC: synchronous clear, accumulate on mac_en, one-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_acc <= '0;
        end else if (mac_clr) begin
            mac_acc <= '0;
        end else if (mac_en) begin
            mac_acc <= mac_acc + macProd;
        end
    end

    // Safety net so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic writeCoef(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = data;
        @(negedge clk);
        coef_wr_en   = 1'b0;
    endtask

    // Offers one sample, then waits (bounded) for out_valid, reporting latency from the acceptance edge.
    task automatic applyStimulus(input logic [15:0] sample, input bit lockWrite,
                                 output int latency, output bit clrSeen, output int enCycles);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = sample;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        latency  = 0;
        enCycles = 0;
        clrSeen  = (mac_clr === 1'b1);
        while (out_valid !== 1'b1 && latency < 40) begin
            @(negedge clk);
            latency++;
            if (mac_en === 1'b1) enCycles++;
            if (lockWrite && latency == 2) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = 2'd2;
                coef_wr_data = 16'h7FFF;
            end else begin
                coef_wr_en = 1'b0;
            end
        end
        coef_wr_en = 1'b0;
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid, mac_en, mac_clr, out_sat} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {in_ready, busy, out_valid, mac_en, mac_clr, out_sat});
        end
        checks++;
        if ({out_data, mac_sample, mac_coeff} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h, expected 0", {out_data, mac_sample, mac_coeff});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_impulse();
        logic [15:0] coefs [4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        logic [15:0] ins   [5] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] exps  [5] = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0000};
        int lat;
        int en;
        bit clr;
        for (int i = 0; i < 4; i++) writeCoef(2'(i), coefs[i]);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ins[i], 1'b0, lat, clr, en);
            checks++;
            if (lat != 6) begin
                errors++;
                $display("[TB] FAIL impulse_latency[%0d]: got %0d, expected 6", i, lat);
            end
            checks++;
            if (!clr || en != 4) begin
                errors++;
                $display("[TB] FAIL impulse_mac_ctrl[%0d]: got clr=%0d en=%0d, expected clr=1 en=4", i, clr, en);
            end
            checks++;
            if (out_data !== exps[i] || out_sat !== 1'b0) begin
                errors++;
                $display("[TB] FAIL impulse_data[%0d]: got %h/%b, expected %h/0", i, out_data, out_sat, exps[i]);
            end
            releaseOutput();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL impulse_return_idle[%0d]: got ready=%b valid=%b, expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        int en;
        bit clr;
        for (int i = 0; i < 4; i++) writeCoef(2'(i), 16'h7FFF);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h7FFF, 1'b0, lat, clr, en);
            if (i == 0) begin
                checks++;
                if (out_data !== 16'h7FFE || out_sat !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sat_first: got %h/%b, expected 7ffe/0", out_data, out_sat);
                end
            end
            if (i == 3) begin
                checks++;
                if (out_data !== SAT_EXP || out_sat !== SAT_FLAG) begin
                    errors++;
                    $display("[TB] FAIL sat_fourth: got %h/%b, expected %h/%b", out_data, out_sat, SAT_EXP, SAT_FLAG);
                end
            end
            releaseOutput();
        end
    endtask

    task automatic test_negative_corner();
        int lat;
        int en;
        bit clr;
        writeCoef(2'd0, 16'h8000);
        for (int i = 1; i < 4; i++) writeCoef(2'(i), 16'h0000);
        applyStimulus(16'h8000, 1'b0, lat, clr, en);
        checks++;
        if (out_data !== NEG_EXP || out_sat !== NEG_FLAG) begin
            errors++;
            $display("[TB] FAIL neg_corner: got %h/%b, expected %h/%b", out_data, out_sat, NEG_EXP, NEG_FLAG);
        end
        releaseOutput();
    endtask

    task automatic test_backpressure();
        int lat;
        int en;
        bit clr;
        writeCoef(2'd0, 16'h4000);
        applyStimulus(16'h2000, 1'b0, lat, clr, en);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d, expected 6", lat);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h1000 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b, expected 1/1000/0", c, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        releaseOutput();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_coef_lockout();
        logic [15:0] ins  [6] = '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000};
        bit          lock [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] exps [6] = '{16'h2000, 16'h0000, 16'h0800, 16'h2000, 16'h0000, 16'h4000};
        int lat;
        int en;
        bit clr;
        doReset();
        writeCoef(2'd0, 16'h4000);
        writeCoef(2'd2, 16'h1000);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) writeCoef(2'd2, 16'h7FFF);
            applyStimulus(ins[i], lock[i], lat, clr, en);
            checks++;
            if (out_data !== exps[i]) begin
                errors++;
                $display("[TB] FAIL lockout_data[%0d]: got %h, expected %h", i, out_data, exps[i]);
            end
            releaseOutput();
        end
    endtask

    task automatic test_reset_mid_acc();
        int lat;
        int en;
        bit clr;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mac_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midacc_in_acc: got mac_en=%b, expected 1", mac_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mac_en, out_valid, in_ready, busy} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL midacc_abort: got %b, expected 0000", {mac_en, out_valid, in_ready, busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({mac_en, out_valid, in_ready} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL midacc_held: got %b, expected 000", {mac_en, out_valid, in_ready});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midacc_release: got %b, expected 1", in_ready);
        end
        applyStimulus(16'h4000, 1'b0, lat, clr, en);
        checks++;
        if (lat != 6 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midacc_zero_coef: got lat=%0d data=%h sat=%b, expected 6/0000/0", lat, out_data, out_sat);
        end
        releaseOutput();
    endtask

    initial begin
        $display("[TB] starting fir_tap_sequencer tests");
        test_reset();
        test_impulse();
        test_saturation();
        test_negative_corner();
        test_backpressure();
        test_coef_lockout();
        test_reset_mid_acc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
